// File: rtl/rgb_stream_packer_if.sv
// Pixel input handshake and packed 32-bit AXI4-Stream output of rgb_stream_packer.
// slave is the packer's view; master is the pixel source / stream sink view.
interface rgb_stream_packer_if;
    logic [7:0]  in_r;
    logic [7:0]  in_g;
    logic [7:0]  in_b;
    logic        in_valid;
    logic        in_ready;
    logic        in_sof;
    logic        in_eol;
    logic [31:0] out_stream_tdata;
    logic [3:0]  out_stream_tkeep;
    logic        out_stream_tlast;
    logic        out_stream_tuser;
    logic        out_stream_tvalid;
    logic        out_stream_tready;

    modport slave (
        input  in_r, in_g, in_b, in_valid, in_sof, in_eol, out_stream_tready,
        output in_ready, out_stream_tdata, out_stream_tkeep, out_stream_tlast,
        output out_stream_tuser, out_stream_tvalid
    );

    modport master (
        output in_r, in_g, in_b, in_valid, in_sof, in_eol, out_stream_tready,
        input  in_ready, out_stream_tdata, out_stream_tkeep, out_stream_tlast,
        input  out_stream_tuser, out_stream_tvalid
    );
endinterface

// File: rtl/rgb_stream_packer.sv
// Packs 24-bit RGB pixels densely into 32-bit stream words (4 pixels -> 3 words),
// with SOF on tuser, EOL on tlast and a flush word for partial groups at line end.
module rgb_stream_packer #(
    parameter logic [7:0] PAD_BYTE = 8'h00
) (
    input  logic              aclk,
    input  logic              aresetn,
    rgb_stream_packer_if.slave bus,
    output logic              sof_misalign
);
    typedef enum logic {RUN, FLUSH} state_t;

    state_t      state, state_nxt;
    logic [1:0]  phase, phase_nxt;
    logic [23:0] hold, hold_nxt;
    logic        hold_sof, hold_sof_nxt;
    logic        flush_two, flush_two_nxt;
    logic        misalign_nxt;
    logic [31:0] tdata_nxt;
    logic [3:0]  tkeep_nxt;
    logic        tlast_nxt, tuser_nxt, tvalid_nxt;
    logic        load_ok, accept;
    logic [23:0] pix;

    assign pix         = {bus.in_r, bus.in_g, bus.in_b};
    assign load_ok     = !bus.out_stream_tvalid || bus.out_stream_tready;
    assign bus.in_ready = aresetn && (state == RUN) && load_ok;
    assign accept      = bus.in_valid && bus.in_ready;

    always_comb begin
        state_nxt     = state;
        phase_nxt     = phase;
        hold_nxt      = hold;
        hold_sof_nxt  = hold_sof;
        flush_two_nxt = flush_two;
        misalign_nxt  = sof_misalign;
        tdata_nxt     = bus.out_stream_tdata;
        tkeep_nxt     = bus.out_stream_tkeep;
        tlast_nxt     = bus.out_stream_tlast;
        tuser_nxt     = bus.out_stream_tuser;
        tvalid_nxt    = bus.out_stream_tvalid && !bus.out_stream_tready;

        if (accept) begin
            if (bus.in_sof && phase != 2'd0)
                misalign_nxt = 1'b1;
            case (phase)
                2'd0: begin
                    if (bus.in_eol) begin
                        tdata_nxt    = {PAD_BYTE, pix};
                        tkeep_nxt    = 4'h7;
                        tlast_nxt    = 1'b1;
                        tuser_nxt    = bus.in_sof;
                        tvalid_nxt   = 1'b1;
                        hold_nxt     = 24'h0;
                        hold_sof_nxt = 1'b0;
                    end else begin
                        // No word yet: the SOF of this pixel rides on the next word.
                        hold_nxt     = pix;
                        hold_sof_nxt = bus.in_sof;
                        phase_nxt    = 2'd1;
                    end
                end
                2'd1: begin
                    tdata_nxt     = {pix[7:0], hold};
                    tkeep_nxt     = 4'hF;
                    tlast_nxt     = 1'b0;
                    tuser_nxt     = hold_sof || bus.in_sof;
                    tvalid_nxt    = 1'b1;
                    hold_sof_nxt  = 1'b0;
                    hold_nxt      = {8'h0, pix[23:8]};
                    flush_two_nxt = 1'b1;
                    phase_nxt     = bus.in_eol ? 2'd0 : 2'd2;
                    state_nxt     = bus.in_eol ? FLUSH : RUN;
                end
                2'd2: begin
                    tdata_nxt     = {pix[15:0], hold[15:0]};
                    tkeep_nxt     = 4'hF;
                    tlast_nxt     = 1'b0;
                    tuser_nxt     = hold_sof || bus.in_sof;
                    tvalid_nxt    = 1'b1;
                    hold_sof_nxt  = 1'b0;
                    hold_nxt      = {16'h0, pix[23:16]};
                    flush_two_nxt = 1'b0;
                    phase_nxt     = bus.in_eol ? 2'd0 : 2'd3;
                    state_nxt     = bus.in_eol ? FLUSH : RUN;
                end
                default: begin
                    tdata_nxt    = {pix, hold[7:0]};
                    tkeep_nxt    = 4'hF;
                    tlast_nxt    = bus.in_eol;
                    tuser_nxt    = hold_sof || bus.in_sof;
                    tvalid_nxt   = 1'b1;
                    hold_sof_nxt = 1'b0;
                    hold_nxt     = 24'h0;
                    phase_nxt    = 2'd0;
                end
            endcase
        end else if (state == FLUSH && load_ok) begin
            // Leftover bytes of a pixel that already opened a word never carry tuser.
            tdata_nxt  = flush_two ? {PAD_BYTE, PAD_BYTE, hold[15:0]}
                                   : {PAD_BYTE, PAD_BYTE, PAD_BYTE, hold[7:0]};
            tkeep_nxt  = flush_two ? 4'h3 : 4'h1;
            tlast_nxt  = 1'b1;
            tuser_nxt  = 1'b0;
            tvalid_nxt = 1'b1;
            hold_nxt   = 24'h0;
            state_nxt  = RUN;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state                 <= RUN;
            phase                 <= 2'd0;
            hold                  <= 24'h0;
            hold_sof              <= 1'b0;
            flush_two             <= 1'b0;
            sof_misalign          <= 1'b0;
            bus.out_stream_tdata  <= 32'h0;
            bus.out_stream_tkeep  <= 4'h0;
            bus.out_stream_tlast  <= 1'b0;
            bus.out_stream_tuser  <= 1'b0;
            bus.out_stream_tvalid <= 1'b0;
        end else begin
            state                 <= state_nxt;
            phase                 <= phase_nxt;
            hold                  <= hold_nxt;
            hold_sof              <= hold_sof_nxt;
            flush_two             <= flush_two_nxt;
            sof_misalign          <= misalign_nxt;
            bus.out_stream_tdata  <= tdata_nxt;
            bus.out_stream_tkeep  <= tkeep_nxt;
            bus.out_stream_tlast  <= tlast_nxt;
            bus.out_stream_tuser  <= tuser_nxt;
            bus.out_stream_tvalid <= tvalid_nxt;
        end
    end
endmodule

// File: tb/tb_rgb_stream_packer.sv
// Directed bench for rgb_stream_packer: drives pixel lines, collects stream words
// and compares them with hand-computed words.
module tb_rgb_stream_packer;
    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    logic misalign;

    rgb_stream_packer_if bus();

    rgb_stream_packer #(.PAD_BYTE(8'h00)) dut (
        .aclk(aclk), .aresetn(aresetn), .bus(bus), .sof_misalign(misalign)
    );

    always #5 aclk = ~aclk;

    typedef struct packed { logic [23:0] p; logic sof; logic eol; } pix_t;
    typedef struct packed { logic [31:0] d; logic [3:0] k; logic l; logic u; } word_t;

    pix_t  pq[$];
    word_t wq[$];
    word_t ew[$];
    int    n_chk = 0;
    int    n_err = 0;
    int    bubbles;
    int    stall_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic add_pix(input logic [23:0] p, input logic sof, input logic eol);
        pix_t x;
        x.p = p; x.sof = sof; x.eol = eol;
        pq.push_back(x);
    endtask

    task automatic exp_word(input logic [31:0] d, input logic [3:0] k, input logic l, input logic u);
        word_t w;
        w.d = d; w.k = k; w.l = l; w.u = u;
        ew.push_back(w);
    endtask

    // mode 0: tready high, mode 1: tready 1,0,0 repeating, mode 2: tready low
    task automatic run(input string tag, input int mode, input int nwords, input int budget);
        int    idx = 0;
        int    cyc = 0;
        logic  stalled = 1'b0;
        logic  done;
        word_t held, cur;
        wq.delete();
        bubbles = 0;
        stall_err = 0;
        held = '0;
        while (!(idx == pq.size() && wq.size() == nwords) && cyc < budget) begin
            @(negedge aclk);
            bus.out_stream_tready = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'b0;
            if (idx < pq.size()) begin
                {bus.in_r, bus.in_g, bus.in_b} = pq[idx].p;
                bus.in_sof = pq[idx].sof;
                bus.in_eol = pq[idx].eol;
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
                bus.in_sof = 1'b0;
                bus.in_eol = 1'b0;
            end
            #1;
            cur.d = bus.out_stream_tdata;
            cur.k = bus.out_stream_tkeep;
            cur.l = bus.out_stream_tlast;
            cur.u = bus.out_stream_tuser;
            if (bus.out_stream_tvalid && stalled && cur !== held) stall_err++;
            if (bus.out_stream_tvalid && bus.out_stream_tready) begin
                wq.push_back(cur);
                stalled = 1'b0;
            end else if (bus.out_stream_tvalid) begin
                held = cur;
                stalled = 1'b1;
            end else begin
                stalled = 1'b0;
            end
            if (bus.in_valid && !bus.in_ready) bubbles++;
            if (bus.in_valid && bus.in_ready) idx++;
            cyc++;
        end
        done = (idx == pq.size() && wq.size() == nwords);
        chk($sformatf("%s.done", tag), {31'd0, done}, 32'd1);
        @(negedge aclk);
        bus.in_valid = 1'b0;
        bus.in_sof = 1'b0;
        bus.in_eol = 1'b0;
        pq.delete();
    endtask

    task automatic check_words(input string tag);
        chk($sformatf("%s.count", tag), wq.size(), ew.size());
        for (int i = 0; i < ew.size(); i++) begin
            if (i < wq.size()) begin
                chk($sformatf("%s[%0d].data", tag, i), wq[i].d, ew[i].d);
                chk($sformatf("%s[%0d].keep", tag, i), {28'd0, wq[i].k}, {28'd0, ew[i].k});
                chk($sformatf("%s[%0d].last", tag, i), {31'd0, wq[i].l}, {31'd0, ew[i].l});
                chk($sformatf("%s[%0d].user", tag, i), {31'd0, wq[i].u}, {31'd0, ew[i].u});
            end else begin
                chk($sformatf("%s[%0d].missing", tag, i), 32'd0, 32'd1);
            end
        end
        ew.delete();
    endtask

    task automatic four_pixels();
        add_pix(24'h010203, 1'b1, 1'b0);
        add_pix(24'h040506, 1'b0, 1'b0);
        add_pix(24'h070809, 1'b0, 1'b0);
        add_pix(24'h0A0B0C, 1'b0, 1'b1);
        exp_word(32'h06010203, 4'hF, 1'b0, 1'b1);
        exp_word(32'h08090405, 4'hF, 1'b0, 1'b0);
        exp_word(32'h0A0B0C07, 4'hF, 1'b1, 1'b0);
    endtask

    initial begin
        logic [23:0] pv[640];
        int bad, nuser, nlast;
        logic [7:0] b;
        logic [31:0] wexp;

        bus.in_r = 8'h0; bus.in_g = 8'h0; bus.in_b = 8'h0;
        bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.in_eol = 1'b0;
        bus.out_stream_tready = 1'b1;

        // Reset state
        #1;
        chk("rst.tvalid", {31'd0, bus.out_stream_tvalid}, 32'd0);
        chk("rst.in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("rst.tdata", bus.out_stream_tdata, 32'd0);
        chk("rst.tkeep", {28'd0, bus.out_stream_tkeep}, 32'd0);
        chk("rst.misalign", {31'd0, misalign}, 32'd0);
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;

        // Full group, tready high, no bubbles
        four_pixels();
        run("t1", 0, 3, 50);
        check_words("t1");
        chk("t1.bubbles", bubbles, 0);

        // Same group under backpressure
        four_pixels();
        run("t2", 1, 3, 100);
        check_words("t2");
        chk("t2.stable", stall_err, 0);

        // Two-pixel line flush, then a one-pixel line behind it
        add_pix(24'h010203, 1'b0, 1'b0);
        add_pix(24'h040506, 1'b0, 1'b1);
        add_pix(24'h111213, 1'b0, 1'b1);
        exp_word(32'h06010203, 4'hF, 1'b0, 1'b0);
        exp_word(32'h00000405, 4'h3, 1'b1, 1'b0);
        exp_word(32'h00111213, 4'h7, 1'b1, 1'b0);
        run("t3", 0, 3, 50);
        check_words("t3");
        chk("t3.bubbles", bubbles, 1);

        // Three-pixel line: flush of a single byte
        add_pix(24'h010203, 1'b0, 1'b0);
        add_pix(24'h040506, 1'b0, 1'b0);
        add_pix(24'h070809, 1'b0, 1'b1);
        exp_word(32'h06010203, 4'hF, 1'b0, 1'b0);
        exp_word(32'h08090405, 4'hF, 1'b0, 1'b0);
        exp_word(32'h00000007, 4'h1, 1'b1, 1'b0);
        run("t3b", 0, 3, 50);
        check_words("t3b");

        // Single pixel with SOF and EOL
        add_pix(24'hAABBCC, 1'b1, 1'b1);
        exp_word(32'h00AABBCC, 4'h7, 1'b1, 1'b1);
        run("t4", 0, 1, 20);
        check_words("t4");
        chk("t4.misalign", {31'd0, misalign}, 32'd0);

        // 640-pixel line against a byte-stream model
        for (int i = 0; i < 640; i++) begin
            pv[i] = 24'(i * 32'h00010203 + 32'h5);
            add_pix(pv[i], i == 0, i == 639);
        end
        run("t5", 0, 480, 2000);
        chk("t5.count", wq.size(), 480);
        bad = 0; nuser = 0; nlast = 0;
        for (int k = 0; k < wq.size() && k < 480; k++) begin
            for (int j = 0; j < 4; j++) begin
                b = 8'(pv[(4 * k + j) / 3] >> (8 * ((4 * k + j) % 3)));
                wexp[8 * j +: 8] = b;
            end
            if (wq[k].d !== wexp || wq[k].k !== 4'hF) bad++;
            if (wq[k].u) nuser++;
            if (wq[k].l) nlast++;
        end
        chk("t5.data", bad, 0);
        if (wq.size() == 480) begin
            chk("t5.user0", {31'd0, wq[0].u}, 32'd1);
            chk("t5.last479", {31'd0, wq[479].l}, 32'd1);
        end
        chk("t5.nuser", nuser, 1);
        chk("t5.nlast", nlast, 1);
        chk("t5.misalign_low", {31'd0, misalign}, 32'd0);

        // SOF landing at phase 2
        add_pix(24'h111111, 1'b0, 1'b0);
        add_pix(24'h222222, 1'b0, 1'b0);
        add_pix(24'h333333, 1'b1, 1'b0);
        add_pix(24'h444444, 1'b0, 1'b1);
        exp_word(32'h22111111, 4'hF, 1'b0, 1'b0);
        exp_word(32'h33332222, 4'hF, 1'b0, 1'b1);
        exp_word(32'h44444433, 4'hF, 1'b1, 1'b0);
        run("t5b", 0, 3, 50);
        check_words("t5b");
        chk("t5b.misalign", {31'd0, misalign}, 32'd1);

        // Reset with a word pending under backpressure
        add_pix(24'h010203, 1'b0, 1'b0);
        add_pix(24'h040506, 1'b0, 1'b0);
        run("t6", 2, 0, 20);
        #1;
        chk("t6.pending", {31'd0, bus.out_stream_tvalid}, 32'd1);
        chk("t6.misalign_sticky", {31'd0, misalign}, 32'd1);
        aresetn = 1'b0;
        #1;
        chk("t6.rst_tvalid", {31'd0, bus.out_stream_tvalid}, 32'd0);
        chk("t6.rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("t6.rst_tdata", bus.out_stream_tdata, 32'd0);
        chk("t6.rst_misalign", {31'd0, misalign}, 32'd0);
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        bus.out_stream_tready = 1'b1;
        repeat (3) @(negedge aclk);
        #1;
        chk("t6.idle", {31'd0, bus.out_stream_tvalid}, 32'd0);
        four_pixels();
        run("t6b", 0, 3, 50);
        check_words("t6b");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
